// File: rtl/axil_register_bank_pkg.sv
// Shared constants and state types for the AXI4-Lite register bank front end.
package axil_register_bank_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [STRB_WIDTH-1:0] STRB_FULL = '1;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axil_register_bank.sv
// AXI4-Lite slave that turns full-word writes into one-hot write pulses for a
// bank of 32-bit registers and returns register contents on reads.
// Write and read paths are independent single-outstanding FSMs.
module axil_register_bank
    import axil_register_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clock,
    input  logic                           resetn,

    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [31:0]                    s_axi_wdata,
    input  logic [3:0]                     s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [31:0]                    s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,

    output logic [NUM_REGS-1:0]            write_enable_o,
    output logic [31:0]                    write_data_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] read_data_i
);

    // Word index width: byte address minus the two ignored LSBs.
    localparam int IDX_W = ADDR_WIDTH - 2;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wr_state_e                 wr_state_q;
    logic                      awready_q;
    logic                      wready_q;
    logic                      aw_held_q;
    logic                      w_held_q;
    logic [IDX_W-1:0]          aw_idx_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [STRB_WIDTH-1:0]     wstrb_q;
    logic                      bvalid_q;
    logic [1:0]                bresp_q;
    logic [NUM_REGS-1:0]       write_enable_q;
    logic [DATA_WIDTH-1:0]     write_data_q;

    logic                      aw_fire;
    logic                      w_fire;
    logic                      aw_have;
    logic                      w_have;
    logic [IDX_W-1:0]          wr_idx_d;
    logic [DATA_WIDTH-1:0]     wr_data_d;
    logic [STRB_WIDTH-1:0]     wr_strb_d;
    logic [NUM_REGS-1:0]       wr_hit_d;
    logic                      wr_accept_d;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rd_state_e                 rd_state_q;
    logic                      arready_q;
    logic                      rvalid_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                rresp_q;

    logic                      ar_fire;
    logic [IDX_W-1:0]          rd_idx_d;
    logic [NUM_REGS-1:0]       rd_hit_d;
    logic [DATA_WIDTH-1:0]     reg_word [NUM_REGS];
    logic [DATA_WIDTH-1:0]     rd_word_d;
    logic [1:0]                rd_resp_d;

    // Byte-lane bits of the addresses carry no meaning for word registers.
    logic                      unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // ------------------------------------------------------------------
    // Write channel capture and decode
    // ------------------------------------------------------------------
    assign aw_fire = s_axi_awvalid & awready_q;
    assign w_fire  = s_axi_wvalid  & wready_q;

    // A channel counts as present if latched earlier or handshaking now,
    // so AW and W may land in either order or together.
    assign aw_have = aw_held_q | aw_fire;
    assign w_have  = w_held_q  | w_fire;

    assign wr_idx_d  = aw_held_q ? aw_idx_q : s_axi_awaddr[ADDR_WIDTH-1:2];
    assign wr_data_d = w_held_q  ? wdata_q  : s_axi_wdata;
    assign wr_strb_d = w_held_q  ? wstrb_q  : s_axi_wstrb;

    // Per-register address match; an out-of-range index matches nothing.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_hit
            assign wr_hit_d[gi] = (wr_idx_d == IDX_W'(gi));
        end
    endgenerate

    // Only full-word writes to an existing register are applied.
    assign wr_accept_d = (|wr_hit_d) && (wr_strb_d == STRB_FULL);

    // Write FSM: collect AW and W, pulse the selected register, then hold B.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_state_q     <= W_IDLE;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            aw_held_q      <= 1'b0;
            w_held_q       <= 1'b0;
            aw_idx_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            bvalid_q       <= 1'b0;
            bresp_q        <= RESP_OKAY;
            write_enable_q <= '0;
            write_data_q   <= '0;
        end else begin
            // The enable is a single-cycle strobe.
            write_enable_q <= '0;
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_idx_q  <= s_axi_awaddr[ADDR_WIDTH-1:2];
                        aw_held_q <= 1'b1;
                    end
                    if (w_fire) begin
                        wdata_q  <= s_axi_wdata;
                        wstrb_q  <= s_axi_wstrb;
                        w_held_q <= 1'b1;
                    end
                    if (aw_have && w_have) begin
                        wr_state_q <= W_RESP;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                        if (wr_accept_d) begin
                            write_enable_q <= wr_hit_d;
                            write_data_q   <= wr_data_d;
                            bresp_q        <= RESP_OKAY;
                        end else begin
                            bresp_q        <= RESP_SLVERR;
                        end
                    end else begin
                        // Keep offering whichever channel is still missing.
                        awready_q <= ~aw_have;
                        wready_q  <= ~w_have;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        wr_state_q <= W_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel decode
    // ------------------------------------------------------------------
    assign ar_fire  = s_axi_arvalid & arready_q;
    assign rd_idx_d = s_axi_araddr[ADDR_WIDTH-1:2];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rd_hit
            assign rd_hit_d[gi] = (rd_idx_d == IDX_W'(gi));
            assign reg_word[gi] = read_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // AND-OR read mux; no hit (out of range) naturally yields zero.
    always_comb begin
        rd_word_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            rd_word_d = rd_word_d | (rd_hit_d[k] ? reg_word[k] : '0);
        end
    end

    assign rd_resp_d = (|rd_hit_d) ? RESP_OKAY : RESP_SLVERR;

    // Read FSM: sample the register on the AR handshake and hold it for R.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        rd_state_q <= R_DATA;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_word_d;
                        rresp_q    <= rd_resp_d;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rd_state_q <= R_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_awready  = awready_q;
    assign s_axi_wready   = wready_q;
    assign s_axi_bvalid   = bvalid_q;
    assign s_axi_bresp    = bresp_q;
    assign s_axi_arready  = arready_q;
    assign s_axi_rvalid   = rvalid_q;
    assign s_axi_rdata    = rdata_q;
    assign s_axi_rresp    = rresp_q;
    assign write_enable_o = write_enable_q;
    assign write_data_o   = write_data_q;

endmodule
